// File: rtl/pll_lock_if.sv
// Signal bundle between the PLL lock sequencer and its surroundings
// (PLL LOCK/RST pins, relock request, system reset and debug counters).
interface pll_lock_if;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [7:0] timeout_count;
    logic [7:0] loss_count;

    // The sequencer drives the PLL reset, system reset and fault counters.
    modport master (
        input  pll_locked,
        input  relock_req,
        output pll_rst,
        output sys_rst,
        output ready,
        output timeout_count,
        output loss_count
    );

    // The environment: PLL LOCK pin, CSR relock request, reset consumers.
    modport slave (
        output pll_locked,
        output relock_req,
        input  pll_rst,
        input  sys_rst,
        input  ready,
        input  timeout_count,
        input  loss_count
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Reset/lock sequencer for the ECP5 EHXPLLL: pulses the PLL reset, waits for a
// continuously stable lock, then releases system reset; re-sequences on faults.
module pll_lock_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 250000,
    parameter int LOCK_STABLE_CYCLES  = 1024
) (
    input  logic       clk,
    input  logic       reset,
    pll_lock_if.master bus
);

    localparam int MAX_AB = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                            RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_P  = (MAX_AB > LOCK_STABLE_CYCLES) ? MAX_AB : LOCK_STABLE_CYCLES;
    localparam int CNT_W  = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    typedef enum logic [1:0] {
        RST_PLL   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t           state_q, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [7:0]       tcnt_q, tcnt_nxt;
    logic [7:0]       lcnt_q, lcnt_nxt;
    logic             sync_p0, sync_p1;
    logic             locked_s;
    logic             pll_rst_q, sys_rst_q, ready_q;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Stage p0/p1: two-flop synchronizer for the asynchronous LOCK pin
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= bus.pll_locked;
            sync_p1 <= sync_p0;
        end
    end

    assign locked_s = sync_p1;

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        tcnt_nxt  = tcnt_q;
        lcnt_nxt  = lcnt_q;
        case (state_q)
            RST_PLL: begin
                if (bus.relock_req) begin
                    cnt_nxt = '0;
                end else if (cnt_q == RST_LAST) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CNT_ONE;
                end
            end
            WAIT_LOCK: begin
                if (bus.relock_req) begin
                    state_nxt = RST_PLL;
                    cnt_nxt   = '0;
                end else if (locked_s) begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_nxt = RST_PLL;
                    cnt_nxt   = '0;
                    tcnt_nxt  = sat_inc(tcnt_q);
                end else begin
                    cnt_nxt = cnt_q + CNT_ONE;
                end
            end
            STABLE: begin
                // Any captured dropout restarts lock acquisition without a fault.
                if (bus.relock_req) begin
                    state_nxt = RST_PLL;
                    cnt_nxt   = '0;
                end else if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_q + CNT_ONE;
                end
            end
            RUN: begin
                if (bus.relock_req) begin
                    state_nxt = RST_PLL;
                    cnt_nxt   = '0;
                end else if (!locked_s) begin
                    state_nxt = RST_PLL;
                    cnt_nxt   = '0;
                    lcnt_nxt  = sat_inc(lcnt_q);
                end
            end
            default: begin
                state_nxt = RST_PLL;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs decode the next state so they switch on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RST_PLL;
            cnt_q     <= '0;
            tcnt_q    <= 8'd0;
            lcnt_q    <= 8'd0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            tcnt_q    <= tcnt_nxt;
            lcnt_q    <= lcnt_nxt;
            pll_rst_q <= (state_nxt == RST_PLL);
            sys_rst_q <= (state_nxt != RUN);
            ready_q   <= (state_nxt == RUN);
        end
    end

    assign bus.pll_rst       = pll_rst_q;
    assign bus.sys_rst       = sys_rst_q;
    assign bus.ready         = ready_q;
    assign bus.timeout_count = tcnt_q;
    assign bus.loss_count    = lcnt_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: reset-release table, hand-written corner
// sequences and a randomized run against a countdown-based behavioural model.
module tb_pll_lock_sequencer;
    localparam int R = 4;
    localparam int S = 8;
    localparam int T = 32;

    localparam int PH_PULSE  = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_STABLE = 2;
    localparam int PH_RUN    = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;

    // Behavioural model: phase, cycles left in the current phase, delay line.
    int   m_phase, m_left, m_tc, m_lc;
    logic m_sh0, m_sh1;

    pll_lock_if bus ();

    pll_lock_sequencer #(
        .RST_PULSE_CYCLES   (R),
        .LOCK_TIMEOUT_CYCLES(T),
        .LOCK_STABLE_CYCLES (S)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rs;
        logic lk;
        logic pr;
        logic sr;
        logic rdy;
        int   tc;
        int   lc;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d, t=%0t)", name, act, exp, edge_n, $time);
        end
    endtask

    task automatic model_step(input logic lk, input logic rq, input logic rs);
        logic ls;
        if (rs) begin
            m_phase = PH_PULSE; m_left = R; m_tc = 0; m_lc = 0; m_sh0 = 0; m_sh1 = 0;
            return;
        end
        ls    = m_sh1;
        m_sh1 = m_sh0;
        m_sh0 = lk;
        if (rq) begin
            m_phase = PH_PULSE; m_left = R;
            return;
        end
        case (m_phase)
            PH_PULSE: begin
                m_left--;
                if (m_left == 0) begin m_phase = PH_WAIT; m_left = T; end
            end
            PH_WAIT: begin
                if (ls) begin
                    m_phase = PH_STABLE; m_left = S;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = PH_PULSE; m_left = R;
                        if (m_tc < 255) m_tc++;
                    end
                end
            end
            PH_STABLE: begin
                if (!ls) begin
                    m_phase = PH_WAIT; m_left = T;
                end else begin
                    m_left--;
                    if (m_left == 0) m_phase = PH_RUN;
                end
            end
            default: begin
                if (!ls) begin
                    m_phase = PH_PULSE; m_left = R;
                    if (m_lc < 255) m_lc++;
                end
            end
        endcase
    endtask

    task automatic tick(input logic lk, input logic rq, input logic rs);
        bus.pll_locked = lk;
        bus.relock_req = rq;
        reset          = rs;
        @(posedge clk);
        model_step(lk, rq, rs);
        edge_n = rs ? 0 : edge_n + 1;
        #1;
        chk("model_pll_rst", int'(bus.pll_rst), int'(m_phase == PH_PULSE));
        chk("model_sys_rst", int'(bus.sys_rst), int'(m_phase != PH_RUN));
        chk("model_ready",   int'(bus.ready),   int'(m_phase == PH_RUN));
        chk("model_timeout", int'(bus.timeout_count), m_tc);
        chk("model_loss",    int'(bus.loss_count),    m_lc);
    endtask

    task automatic run_to(input logic lk, input int target);
        for (int i = 0; i < 20000 && edge_n < target; i++) tick(lk, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
    endtask

    logic lk_r;

    initial begin
        bus.pll_locked = 1'b0;
        bus.relock_req = 1'b0;

        // Reset release with lock constantly high: rs, lk, pll_rst, sys_rst, ready, tc, lc
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0};  // edge 1
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0};  // edge 3
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0};  // edge 4
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0};  // edge 12
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0};  // edge 13
        tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0};

        for (int i = 0; i < 16; i++) begin
            tick(tbl[i].lk, 1'b0, tbl[i].rs);
            chk("t1_pll_rst", int'(bus.pll_rst), int'(tbl[i].pr));
            chk("t1_sys_rst", int'(bus.sys_rst), int'(tbl[i].sr));
            chk("t1_ready",   int'(bus.ready),   int'(tbl[i].rdy));
            chk("t1_timeout", int'(bus.timeout_count), tbl[i].tc);
            chk("t1_loss",    int'(bus.loss_count),    tbl[i].lc);
        end

        // Lock never arrives: timeouts at R+T and every R+T after, saturating
        do_reset();
        run_to(1'b0, 35);
        chk("t2_pll_rst_35", int'(bus.pll_rst), 0);
        chk("t2_tc_35", int'(bus.timeout_count), 0);
        tick(1'b0, 1'b0, 1'b0);
        chk("t2_pll_rst_36", int'(bus.pll_rst), 1);
        chk("t2_tc_36", int'(bus.timeout_count), 1);
        run_to(1'b0, 71);
        chk("t2_tc_71", int'(bus.timeout_count), 1);
        tick(1'b0, 1'b0, 1'b0);
        chk("t2_tc_72", int'(bus.timeout_count), 2);
        run_to(1'b0, 300 * (R + T));
        chk("t2_tc_sat", int'(bus.timeout_count), 255);
        chk("t2_lc_sat", int'(bus.loss_count), 0);

        // Dropout during STABLE restarts acquisition without counting a fault
        do_reset();
        run_to(1'b0, 9);
        run_to(1'b1, 13);
        run_to(1'b0, 16);
        chk("t3_sys_rst_16", int'(bus.sys_rst), 1);
        run_to(1'b1, 26);
        chk("t3_ready_26", int'(bus.ready), 0);
        tick(1'b1, 1'b0, 1'b0);
        chk("t3_ready_27", int'(bus.ready), 1);
        chk("t3_tc", int'(bus.timeout_count), 0);
        chk("t3_lc", int'(bus.loss_count), 0);

        // Lock loss in RUN: three edges to sys_rst, counted, full re-sequence
        do_reset();
        run_to(1'b1, 15);
        chk("t4_ready_15", int'(bus.ready), 1);
        run_to(1'b0, 17);
        chk("t4_sys_rst_17", int'(bus.sys_rst), 0);
        tick(1'b0, 1'b0, 1'b0);
        chk("t4_sys_rst_18", int'(bus.sys_rst), 1);
        chk("t4_pll_rst_18", int'(bus.pll_rst), 1);
        chk("t4_lc_18", int'(bus.loss_count), 1);
        run_to(1'b0, 20);
        run_to(1'b1, 30);
        chk("t4_ready_30", int'(bus.ready), 0);
        tick(1'b1, 1'b0, 1'b0);
        chk("t4_ready_31", int'(bus.ready), 1);
        chk("t4_lc_31", int'(bus.loss_count), 1);

        // relock_req in RUN, then again at RST_PLL cnt=2 restarts the pulse
        do_reset();
        run_to(1'b1, 14);
        tick(1'b1, 1'b1, 1'b0);
        chk("t5_pll_rst_15", int'(bus.pll_rst), 1);
        run_to(1'b1, 17);
        tick(1'b1, 1'b1, 1'b0);
        run_to(1'b1, 21);
        chk("t5_pll_rst_21", int'(bus.pll_rst), 1);
        tick(1'b1, 1'b0, 1'b0);
        chk("t5_pll_rst_22", int'(bus.pll_rst), 0);
        chk("t5_tc", int'(bus.timeout_count), 0);
        chk("t5_lc", int'(bus.loss_count), 0);

        // Reset for one cycle while STABLE, then sequence restarts from edge 1
        do_reset();
        run_to(1'b1, 8);
        tick(1'b1, 1'b0, 1'b1);
        chk("t6_pll_rst_rst", int'(bus.pll_rst), 1);
        chk("t6_sys_rst_rst", int'(bus.sys_rst), 1);
        chk("t6_ready_rst", int'(bus.ready), 0);
        run_to(1'b1, 3);
        chk("t6_pll_rst_3", int'(bus.pll_rst), 1);
        tick(1'b1, 1'b0, 1'b0);
        chk("t6_pll_rst_4", int'(bus.pll_rst), 0);
        run_to(1'b1, 12);
        chk("t6_ready_12", int'(bus.ready), 0);
        tick(1'b1, 1'b0, 1'b0);
        chk("t6_ready_13", int'(bus.ready), 1);

        // Randomized lock dropouts, relock requests and resets vs the model
        do_reset();
        lk_r = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 39) == 0) lk_r = ~lk_r;
            tick(lk_r, ($urandom_range(0, 99) == 0), ($urandom_range(0, 799) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Reset and lock sequencer for the ECP5 `EHXPLLL`-based clock generator (25 MHz in, 100 MHz out). It runs in the 25 MHz reference domain and drives the PLL `RST` pin. It watches the asynchronous `LOCK` output and holds the downstream system in reset until lock has been continuously stable. It re-sequences the PLL on lock loss, on lock-acquisition timeout, or on explicit request, and keeps saturating fault counters for debug/CSR readout.

## Interface
Parameters:
- `RST_PULSE_CYCLES`, 16: cycles `pll_rst` is held high per reset pulse; must be ≥ 2.
- `LOCK_TIMEOUT_CYCLES`, 250000: maximum cycles spent waiting for lock before re-pulsing `pll_rst` (10 ms at 25 MHz).
- `LOCK_STABLE_CYCLES`, 1024: cycles of continuous synchronized lock required before releasing system reset.

Ports:
- `clk`  in  1: 25 MHz reference clock, same net as the PLL `CLKI`.
- `reset`  in  1: synchronous, active-high.
- `pll_locked`  in  1: PLL `LOCK`, asynchronous to `clk`.
- `relock_req`  in  1: single-cycle request to re-sequence the PLL.
- `pll_rst`  out  1: to PLL `RST`; active-high.
- `sys_rst`  out  1: active-high system reset. The consumer re-synchronizes it into the 100 MHz domain.
- `ready`  out  1: high only in RUN.
- `timeout_count`  out  8: count of lock-acquisition timeouts, saturating at 255.
- `loss_count`  out  8: count of lock losses while in RUN, saturating at 255.

## Operation
- Input synchronization:
  - `pll_locked` passes through a 2-flop synchronizer, producing `locked_s`.
  - Both synchronizer flops reset to 0.
  - All decisions use `locked_s` only.
- Single down-counter-free design:
  - One up-counter `cnt`, sized to `$clog2` of the largest parameter.
  - `cnt` is cleared on every state change.
- States and transitions (`relock_req` has highest priority in every state):
  - RST_PLL:
    - If `relock_req`: `cnt`←0 and stay (restarts the pulse).
    - Else if `cnt==RST_PULSE_CYCLES-1`: →WAIT_LOCK.
    - Else: `cnt`++.
  - WAIT_LOCK:
    - If `relock_req`: →RST_PLL.
    - Else if `locked_s`: →STABLE.
    - Else if `cnt==LOCK_TIMEOUT_CYCLES-1`: →RST_PLL, `timeout_count`++ (saturating).
    - Else: `cnt`++.
  - STABLE:
    - If `relock_req`: →RST_PLL.
    - Else if `!locked_s`: →WAIT_LOCK. The timeout restarts; this is not counted as a fault.
    - Else if `cnt==LOCK_STABLE_CYCLES-1`: →RUN.
    - Else: `cnt`++.
  - RUN:
    - If `relock_req`: →RST_PLL. Not counted.
    - Else if `!locked_s`: →RST_PLL, `loss_count`++ (saturating).
- Outputs are registered, decoded from next-state, so they change on the same edge as the state:
  - `pll_rst` = (state==RST_PLL).
  - `sys_rst` = (state!=RUN).
  - `ready` = (state==RUN).
- Counters saturate at 255 and never wrap. They are cleared only by `reset`, not by `relock_req`.

## Timing
- Reset values (while `reset` is high and on the edge where it is sampled):
  - State RST_PLL, `cnt`=0.
  - `pll_rst`=1, `sys_rst`=1, `ready`=0.
  - `timeout_count`=0, `loss_count`=0.
  - Synchronizer flops = 0.
- Edge numbering: edge 1 is the first rising edge with `reset` low.
- `pll_rst` stays high through edge R−1 and falls at edge R, where R=`RST_PULSE_CYCLES`. It is therefore high for exactly R cycles after reset release.
- Lock already present (`pll_locked` high since before reset release):
  - STABLE is entered at edge R+1.
  - `ready` rises and `sys_rst` falls at edge R+S+1, where S=`LOCK_STABLE_CYCLES`.
- Lock never arrives:
  - `pll_rst` re-asserts and `timeout_count` increments at edge R+T, where T=`LOCK_TIMEOUT_CYCLES`.
  - This repeats every R+T cycles.
- Lock loss in RUN:
  - `pll_locked` falls; `locked_s` falls 2 edges later.
  - On the following edge: `sys_rst`=1, `ready`=0, `pll_rst`=1.
  - Total: 3 edges from the `pll_locked` fall to `sys_rst` assertion.
- Lock glitch shorter than the synchronizer window:
  - A glitch in RUN that is captured by the synchronizer is treated as a real loss.
  - In STABLE, any captured glitch restarts the full stability window.
- `reset` asserted mid-sequence: takes effect on the next edge from any state and forces the reset values above.

## Test plan
Parameters for all scenarios: R=4, S=8, T=32.

1. Reset release with `pll_locked`=1 constant -> `pll_rst` high for edges 1–3 and low at edge 4; `ready`=1 and `sys_rst`=0 at edge 13; both counters 0.
2. `pll_locked`=0 forever -> `pll_rst` re-asserts at edge 36; `timeout_count`=1 at edge 36 and 2 at edge 72. Run 300 timeouts -> `timeout_count` holds at 255.
3. Lock rises at edge 10, drops for 3 cycles during STABLE, then stays high -> state returns to WAIT_LOCK with no counter change; `ready` rises exactly S+1 edges after `locked_s` re-rises.
4. In RUN, drop `pll_locked` for 5 cycles -> `sys_rst`=1 and `pll_rst`=1 three edges after the drop; `loss_count`=1; `ready` re-asserts after a full R+S+1 sequence once lock returns.
5. `relock_req` pulse in RUN, then a second pulse at RST_PLL `cnt`=2 -> `pll_rst` is held for 4 cycles after the second pulse; both counters remain 0.
6. Assert `reset` for 1 cycle while in STABLE -> all outputs return to reset values on that edge; the sequence restarts from edge 1 timing.
